// File: rtl/ro_enc_pkg.sv
// Shared constants for the panel rotary-encoder A/B generator and its decoder:
// FSM encoding, Gray line states and direction codes.
package ro_enc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HALF1  = 3'd1;
    localparam logic [2:0] ST_HALF2  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_10 = 2'b10;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // One quarter step around the ring 00-01-11-10 (CW) or its reverse (CCW).
    function automatic logic [1:0] gray_next(input logic [1:0] ab, input logic dir);
        logic [1:0] nxt;
        nxt = AB_00;
        if (dir == DIR_CW) begin
            case (ab)
                AB_00:   nxt = AB_01;
                AB_01:   nxt = AB_11;
                AB_11:   nxt = AB_10;
                default: nxt = AB_00;
            endcase
        end else begin
            case (ab)
                AB_00:   nxt = AB_10;
                AB_10:   nxt = AB_11;
                AB_11:   nxt = AB_01;
                default: nxt = AB_00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ro_enc_gen_if.sv
// Command/status bundle between a controller and the rotary-encoder A/B generator.
interface ro_enc_gen_if #(
    parameter int CNT_W = 5,
    parameter int DIV_W = 16
);
    logic             i_start;
    logic             i_dir;
    logic [CNT_W-1:0] i_steps;
    logic [DIV_W-1:0] i_period;
    logic             i_abort;
    logic             o_busy;
    logic             o_done;
    logic             o_aborted;
    logic [CNT_W-1:0] o_steps_left;
    logic             o_ro_enc_state_a;
    logic             o_ro_enc_state_b;

    modport master (
        output i_start, i_dir, i_steps, i_period, i_abort,
        input  o_busy, o_done, o_aborted, o_steps_left,
               o_ro_enc_state_a, o_ro_enc_state_b
    );

    modport slave (
        input  i_start, i_dir, i_steps, i_period, i_abort,
        output o_busy, o_done, o_aborted, o_steps_left,
               o_ro_enc_state_a, o_ro_enc_state_b
    );
endinterface

// File: rtl/ro_enc_tick_timer.sv
// Loadable down-counter that pulses o_tick once every loaded-period cycles
// and reloads itself; also suitable as a debounce timebase.
module ro_enc_tick_timer #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tick
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] reload_q;

    assign o_tick = i_en && (count_q == '0);

    // Counting from period-1 down to 0 makes the tick land on the period-th edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q  <= '0;
            reload_q <= ONE;
        end else if (i_load) begin
            reload_q <= i_load_val;
            count_q  <= i_load_val - ONE;
        end else if (o_tick) begin
            count_q  <= reload_q - ONE;
        end else if (i_en) begin
            count_q  <= count_q - ONE;
        end
    end

endmodule

// File: rtl/ro_enc_gen.sv
// Quadrature A/B generator: emits a commanded number of Gray-coded detents at a
// programmable transition period, always stopping at a rest state (00 or 11).
module ro_enc_gen
    import ro_enc_pkg::*;
#(
    parameter int CNT_W = 5,
    parameter int DIV_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    ro_enc_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] STEP_ONE   = CNT_W'(1);
    localparam logic [DIV_W-1:0] PERIOD_ONE = DIV_W'(1);

    logic [2:0]       state_q;
    logic             dir_q;
    logic             abort_pend_q;
    logic             aborted_q;
    logic [CNT_W-1:0] steps_left_q;
    logic [1:0]       ab_q;
    logic             accept;
    logic             timer_en;
    logic             tick;
    logic [DIV_W-1:0] period_eff;

    assign accept     = (state_q == ST_IDLE) && bus.i_start;
    assign period_eff = (bus.i_period == '0) ? PERIOD_ONE : bus.i_period;
    assign timer_en   = (state_q == ST_HALF1) || (state_q == ST_HALF2) ||
                        (state_q == ST_SETTLE);

    ro_enc_tick_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (accept),
        .i_load_val (period_eff),
        .i_en       (timer_en),
        .o_tick     (tick)
    );

    // Each timer tick performs exactly one line transition or the settle exit;
    // a pending abort is honoured only where a new detent would begin.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_CW;
            aborted_q    <= 1'b0;
            steps_left_q <= '0;
            ab_q         <= AB_00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        dir_q        <= bus.i_dir;
                        steps_left_q <= bus.i_steps;
                        aborted_q    <= 1'b0;
                        state_q      <= (bus.i_steps == '0) ? ST_DONE : ST_HALF1;
                    end
                end
                ST_HALF1: begin
                    if (tick) begin
                        if (abort_pend_q) begin
                            aborted_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            ab_q    <= gray_next(ab_q, dir_q);
                            state_q <= ST_HALF2;
                        end
                    end
                end
                ST_HALF2: begin
                    if (tick) begin
                        ab_q         <= gray_next(ab_q, dir_q);
                        steps_left_q <= steps_left_q - STEP_ONE;
                        state_q      <= (steps_left_q == STEP_ONE) ? ST_SETTLE : ST_HALF1;
                    end
                end
                ST_SETTLE: begin
                    if (tick) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Abort requests are remembered while busy and forgotten once the command ends.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            abort_pend_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            abort_pend_q <= 1'b0;
        end else if ((state_q != ST_IDLE) && bus.i_abort) begin
            abort_pend_q <= 1'b1;
        end
    end

    assign bus.o_busy           = (state_q != ST_IDLE);
    assign bus.o_done           = (state_q == ST_DONE);
    assign bus.o_aborted        = aborted_q;
    assign bus.o_steps_left     = steps_left_q;
    assign bus.o_ro_enc_state_a = ab_q[1];
    assign bus.o_ro_enc_state_b = ab_q[0];

endmodule

// File: tb/tb_ro_enc_gen.sv
// Self-checking bench for ro_enc_gen: cycle-accurate timing model per command plus
// a completion scoreboard, a Gray-step watcher and a quadrature decoder model.
module tb_ro_enc_gen;

    localparam int CNT_W = 5;
    localparam int DIV_W = 16;

    typedef struct {
        int         lat;
        logic       aborted;
        logic [4:0] left;
        logic [1:0] ab;
        int         trans;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst;

    ro_enc_gen_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

    ro_enc_gen #(
        .CNT_W(CNT_W),
        .DIV_W(DIV_W)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         t_acc       = 0;
    int         mon_trans   = 0;
    int         half_acc    = 0;
    int         done_cnt    = 0;
    logic       mon_dir     = 1'b0;
    logic [1:0] mon_ab      = 2'b00;
    logic [1:0] mon_cur;
    logic [1:0] exp_rest    = 2'b00;
    exp_t       sb_q[$];
    exp_t       mon_e;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Independent table of the quadrature ring used by the watcher and the timing model.
    function automatic logic [1:0] tb_next(input logic [1:0] ab, input logic ccw);
        logic [1:0] r;
        r = 2'b00;
        case ({ccw, ab})
            3'b0_00: r = 2'b01;
            3'b0_01: r = 2'b11;
            3'b0_11: r = 2'b10;
            3'b0_10: r = 2'b00;
            3'b1_00: r = 2'b10;
            3'b1_10: r = 2'b11;
            3'b1_11: r = 2'b01;
            3'b1_01: r = 2'b00;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    always @(negedge i_clk) begin
        if (i_rst) begin
            mon_ab = 2'b00;
        end else begin
            mon_cur = {bus.o_ro_enc_state_a, bus.o_ro_enc_state_b};
            if (mon_cur !== mon_ab) begin
                checkOutput("gray_step", mon_cur, tb_next(mon_ab, mon_dir));
                if (mon_cur == tb_next(mon_ab, 1'b0)) half_acc++;
                else if (mon_cur == tb_next(mon_ab, 1'b1)) half_acc--;
                mon_ab = mon_cur;
                mon_trans++;
            end
            if (bus.o_done === 1'b1) begin
                done_cnt++;
                checkOutput("sb_has_entry", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.lat >= 0) checkOutput("done_latency", cyc - t_acc, mon_e.lat);
                    checkOutput("aborted", bus.o_aborted, mon_e.aborted);
                    checkOutput("left_at_done", bus.o_steps_left, mon_e.left);
                    checkOutput("ab_at_done", mon_cur, mon_e.ab);
                    checkOutput("trans_count", mon_trans, mon_e.trans);
                end
            end
        end
    end

    task automatic applyStimulus(input logic dir, input int steps, input int period,
                                 input int abort_edge, input bit exp_abort, input int sent,
                                 input bit restart);
        int         p;
        int         done_k;
        int         limit;
        int         sent_n;
        int         sl_e;
        logic [1:0] ab_e;
        exp_t       e;
        p      = (period == 0) ? 1 : period;
        done_k = (steps == 0) ? 0 : (2 * steps + 1) * p;
        limit  = exp_abort ? 3000 : done_k + 1;
        sent_n = exp_abort ? sent : steps;
        e.lat     = exp_abort ? -1 : done_k;
        e.aborted = exp_abort;
        e.left    = 5'(steps - sent_n);
        e.ab      = sent_n[0] ? ~exp_rest : exp_rest;
        e.trans   = 2 * sent_n;

        @(negedge i_clk);
        bus.i_dir    = dir;
        bus.i_steps  = CNT_W'(steps);
        bus.i_period = DIV_W'(period);
        bus.i_start  = 1'b1;
        mon_dir      = dir;
        mon_trans    = 0;
        sb_q.push_back(e);
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        t_acc       = cyc;
        ab_e        = exp_rest;
        sl_e        = steps;

        for (int k = 0; k <= limit; k++) begin
            if (k > 0) begin
                @(posedge i_clk);
                #1;
            end
            if (restart && k == 0) begin
                bus.i_start = 1'b1;
                bus.i_steps = CNT_W'(7);
                bus.i_dir   = ~dir;
            end else if (restart && k == 1) begin
                bus.i_start = 1'b0;
            end
            if (abort_edge > 0 && k == abort_edge - 1) bus.i_abort = 1'b1;
            else if (abort_edge > 0 && k == abort_edge) bus.i_abort = 1'b0;
            if (exp_abort) begin
                if (sb_q.size() == 0) break;
            end else begin
                if (k > 0 && (k % p) == 0 && (k / p) <= 2 * steps) begin
                    ab_e = tb_next(ab_e, dir);
                    if ((k % (2 * p)) == 0) sl_e--;
                end
                if (k <= done_k) begin
                    checkOutput("ab_line", {bus.o_ro_enc_state_a, bus.o_ro_enc_state_b}, ab_e);
                    checkOutput("steps_left", bus.o_steps_left, sl_e);
                    checkOutput("busy", bus.o_busy, 1);
                    checkOutput("done", bus.o_done, k == done_k);
                end else begin
                    checkOutput("busy_after_done", bus.o_busy, 0);
                    checkOutput("done_after_done", bus.o_done, 0);
                end
            end
        end
        bus.i_abort = 1'b0;
        checkOutput("sb_drained", sb_q.size(), 0);
        sb_q.delete();
        exp_rest = e.ab;
    endtask

    initial begin
        int d;
        int s;
        int pr;
        int h0;
        int dc0;
        i_rst        = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_dir    = 1'b0;
        bus.i_steps  = '0;
        bus.i_period = '0;
        bus.i_abort  = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_ab", {bus.o_ro_enc_state_a, bus.o_ro_enc_state_b}, 2'b00);
        checkOutput("rst_busy", bus.o_busy, 0);
        checkOutput("rst_done", bus.o_done, 0);
        checkOutput("rst_aborted", bus.o_aborted, 0);
        checkOutput("rst_steps_left", bus.o_steps_left, 0);
        i_rst = 1'b0;

        applyStimulus(1'b0, 1, 4, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 2, 2, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 5, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1, 0, 0, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, 5, 3, 10, 1'b1, 2, 1'b0);
        applyStimulus(1'b1, 4, 3, 1, 1'b1, 0, 1'b0);
        applyStimulus(1'b1, 1, 2, 5, 1'b0, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            d  = int'($urandom_range(0, 1));
            s  = int'($urandom_range(0, 6));
            pr = int'($urandom_range(0, 4));
            applyStimulus(d[0], s, pr, 0, 1'b0, 0, 1'b0);
        end

        h0 = half_acc;
        applyStimulus(1'b0, 31, 100, 0, 1'b0, 0, 1'b0);
        checkOutput("decoder_cw", half_acc - h0, 62);
        h0 = half_acc;
        applyStimulus(1'b1, 31, 100, 0, 1'b0, 0, 1'b0);
        checkOutput("decoder_ccw", half_acc - h0, -62);

        @(negedge i_clk);
        bus.i_dir    = 1'b0;
        bus.i_steps  = CNT_W'(3);
        bus.i_period = DIV_W'(5);
        bus.i_start  = 1'b1;
        mon_dir      = 1'b0;
        mon_trans    = 0;
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        dc0 = done_cnt;
        repeat (7) @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        checkOutput("midrst_ab", {bus.o_ro_enc_state_a, bus.o_ro_enc_state_b}, 2'b00);
        checkOutput("midrst_busy", bus.o_busy, 0);
        checkOutput("midrst_done", bus.o_done, 0);
        checkOutput("midrst_steps_left", bus.o_steps_left, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        exp_rest = 2'b00;
        repeat (10) @(posedge i_clk);
        #1;
        checkOutput("midrst_no_done", done_cnt - dc0, 0);

        applyStimulus(1'b0, 1, 2, 0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
